bus_beat_seq: RTL and testbench

BUS_BEAT_SEQ -- requirements
Module: bus_beat_seq

---
 rtl/bus_beat_seq.sv | 221 ++++++++++++++++++++++
 tb/tb_bus_beat_seq.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_beat_seq.sv
// bus_beat_seq: splits a 1/2/4-beat read or write request into byte-wide
// bus beats, handshaking each beat with a strobe / ready protocol, and
// assembles little-endian read data with optional sign extension.
//
// Parameters:
//   ADDR_W  - bus and request address width
//   DATA_W  - request data width (8, 16 or 32)
//   TIMEOUT - max cycles spent waiting on the slave (BUS_TIMEOUT_EN only)
//
// Ports:
//   i_clk, i_rst        - clock, synchronous active-high reset
//   i_req, i_we         - transfer request (sampled in IDLE), write enable
//   i_addr, i_size      - first-beat byte address, beat count code (0/1/2)
//   i_sext, i_wdata     - sign-extend read result, write data
//   o_busy, o_done      - not-idle flag, one-cycle completion pulse
//   o_err, o_rdata      - error flag (valid with o_done), read result
//   o_bus_clk, o_bus_we - bus strobe and write enable
//   o_bus_addr          - beat address
//   o_bus_data          - beat write data
//   i_bus_data          - beat read data
//   i_bus_data_ready    - slave ready/acknowledge
//
// Build option: define BUS_TIMEOUT_EN to abort a transfer whose slave does
// not respond within TIMEOUT cycles.
module bus_beat_seq #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [1:0]        i_size,
    input  logic              i_sext,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_bus_clk,
    output logic              o_bus_we,
    output logic [ADDR_W-1:0] o_bus_addr,
    output logic [7:0]        o_bus_data,
    input  logic [7:0]        i_bus_data,
    input  logic              i_bus_data_ready
);

    localparam int          NB       = DATA_W / 8;
    localparam logic [1:0]  LAST_MAX = 2'(NB - 1);

    typedef enum logic [2:0] {
        IDLE,
        STROBE,
        WAIT,
        RELEASE,
        DONE
    } state_t;

    state_t state, state_nx;

    logic                   we_q;
    logic                   sext_q;
    logic [ADDR_W-1:0]      addr_q;
    logic [NB-1:0][7:0]     wdata_q;
    logic [NB-1:0][7:0]     rbuf;
    logic [1:0]             beat_q;
    logic [1:0]             last_q;
    logic                   err_q;
    logic [DATA_W-1:0]      rdata_q;
    logic                   bus_clk_q;
    logic                   bus_we_q;
    logic [ADDR_W-1:0]      bus_addr_q;
    logic [7:0]             bus_data_q;
    logic [1:0]             last_req;
    logic [NB-1:0][7:0]     rdata_fill;
    logic [7:0]             fill_byte;
    logic                   to_hit;

`ifdef BUS_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] to_cnt;

    // Counts every cycle spent in WAIT/RELEASE for the current beat.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            to_cnt <= '0;
        end else if (state == STROBE) begin
            to_cnt <= '0;
        end else if ((state == WAIT || state == RELEASE) && !to_hit) begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end

    assign to_hit = (state == WAIT || state == RELEASE) &&
                    (to_cnt == TO_W'(TIMEOUT - 1));
`else
    assign to_hit = 1'b0;
`endif

    // Last beat index requested, clamped to the data width.
    always_comb begin
        case (i_size)
            2'd0:    last_req = 2'd0;
            2'd1:    last_req = 2'd1;
            default: last_req = 2'd3;
        endcase
        if (last_req > LAST_MAX) last_req = LAST_MAX;
    end

    // Received bytes kept; bytes above the last one zero- or sign-filled.
    always_comb begin
        rdata_fill = '0;
        fill_byte  = (sext_q && rbuf[last_q][7]) ? 8'hFF : 8'h00;
        for (int unsigned i = 0; i < NB; i++) begin
            rdata_fill[2'(i)] = (2'(i) <= last_q) ? rbuf[2'(i)] : fill_byte;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (i_req) state_nx = (i_size == 2'd3) ? DONE : STROBE;
            STROBE:  state_nx = WAIT;
            WAIT: begin
                if (i_bus_data_ready) state_nx = RELEASE;
                else if (to_hit)      state_nx = DONE;
            end
            RELEASE: begin
                if (!i_bus_data_ready) state_nx = (beat_q == last_q) ? DONE : STROBE;
                else if (to_hit)       state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Bus outputs are registered: the strobe becomes visible the cycle after
    // STROBE and drops the cycle after the slave acknowledges in WAIT.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            we_q       <= 1'b0;
            sext_q     <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rbuf       <= '0;
            beat_q     <= '0;
            last_q     <= '0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            bus_clk_q  <= 1'b0;
            bus_we_q   <= 1'b0;
            bus_addr_q <= '0;
            bus_data_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req) begin
                        if (i_size == 2'd3) begin
                            err_q <= 1'b1;
                        end else begin
                            err_q   <= 1'b0;
                            we_q    <= i_we;
                            sext_q  <= i_sext;
                            addr_q  <= i_addr;
                            wdata_q <= i_wdata;
                            beat_q  <= '0;
                            last_q  <= last_req;
                            rbuf    <= '0;
                        end
                    end
                end
                STROBE: begin
                    bus_clk_q  <= 1'b1;
                    bus_we_q   <= we_q;
                    bus_addr_q <= addr_q + ADDR_W'(beat_q);
                    bus_data_q <= we_q ? wdata_q[beat_q] : 8'h00;
                end
                WAIT: begin
                    if (i_bus_data_ready) begin
                        bus_clk_q <= 1'b0;
                        bus_we_q  <= 1'b0;
                        if (!we_q) rbuf[beat_q] <= i_bus_data;
                    end else if (to_hit) begin
                        bus_clk_q <= 1'b0;
                        bus_we_q  <= 1'b0;
                        err_q     <= 1'b1;
                    end
                end
                RELEASE: begin
                    if (!i_bus_data_ready) begin
                        if (beat_q == last_q) begin
                            if (!we_q) rdata_q <= rdata_fill;
                        end else begin
                            beat_q <= beat_q + 2'd1;
                        end
                    end else if (to_hit) begin
                        err_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy     = (state != IDLE);
    assign o_done     = (state == DONE);
    assign o_err      = (state == DONE) && err_q;
    assign o_rdata    = rdata_q;
    assign o_bus_clk  = bus_clk_q;
    assign o_bus_we   = bus_we_q;
    assign o_bus_addr = bus_addr_q;
    assign o_bus_data = bus_data_q;

endmodule

// File: tb/tb_bus_beat_seq.sv
// Testbench for bus_beat_seq: scoreboard of expected bus beats and transfer
// results, checked against a zero-wait slave driven from the bench.
module tb_bus_beat_seq;

`ifdef BUS_TIMEOUT_EN
    localparam int TO = 10;
`else
    localparam int TO = 255;
`endif

    logic        i_clk;
    logic        i_rst;
    logic        i_req;
    logic        i_we;
    logic [31:0] i_addr;
    logic [1:0]  i_size;
    logic        i_sext;
    logic [31:0] i_wdata;
    logic        o_busy;
    logic        o_done;
    logic        o_err;
    logic [31:0] o_rdata;
    logic        o_bus_clk;
    logic        o_bus_we;
    logic [31:0] o_bus_addr;
    logic [7:0]  o_bus_data;
    logic [7:0]  i_bus_data;
    logic        i_bus_data_ready;

    bus_beat_seq #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_we(i_we),
        .i_addr(i_addr), .i_size(i_size), .i_sext(i_sext), .i_wdata(i_wdata),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_rdata(o_rdata),
        .o_bus_clk(o_bus_clk), .o_bus_we(o_bus_we), .o_bus_addr(o_bus_addr),
        .o_bus_data(o_bus_data), .i_bus_data(i_bus_data),
        .i_bus_data_ready(i_bus_data_ready)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [7:0]  data;
    } beat_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
    } res_t;

    beat_t       beat_sb[$];
    res_t        res_sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] last_rdata = '0;

    function automatic logic [31:0] model_rdata(input logic [31:0] bytes,
                                                input logic [1:0] size,
                                                input logic sext);
        int          n;
        logic        fill;
        logic [31:0] r;
        n    = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        fill = sext & bytes[n*8-1];
        for (int i = 0; i < 4; i++)
            r[i*8 +: 8] = (i < n) ? bytes[i*8 +: 8] : {8{fill}};
        return r;
    endfunction

    task automatic run_xfer(input logic we, input logic [31:0] addr,
                            input logic [1:0] size, input logic sext,
                            input logic [31:0] wdata, input logic [31:0] rbytes,
                            input bit stall, input bit poke, input string name);
        int    n, cyc, sst, bi;
        bit    done, bad_we, prev_clk;
        beat_t b;
        res_t  r;
        n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : (size == 2'd2) ? 4 : 0;
        for (int i = 0; i < (stall ? 1 : n); i++) begin
            b.addr = addr + 32'(i);
            b.we   = we;
            b.data = wdata[i*8 +: 8];
            beat_sb.push_back(b);
        end
        r.err   = (size == 2'd3) || stall;
        r.rdata = (!we && !r.err) ? model_rdata(rbytes, size, sext) : last_rdata;
        r.lat   = (size == 2'd3) ? 1 : stall ? TO + 2 : 4 * n + 1;
        res_sb.push_back(r);

        i_we = we; i_addr = addr; i_size = size; i_sext = sext; i_wdata = wdata;
        i_req = 1'b1;
        @(negedge i_clk);
        i_req = 1'b0;
        cyc = 1; sst = 0; bi = 0; done = 0; bad_we = 0; prev_clk = 0;
        while (!done && cyc < 400) begin
            if (poke && cyc == 2) begin i_req = 1'b1; i_addr = ~addr; end
            if (poke && cyc == 3) i_req = 1'b0;
            if (o_bus_clk && !prev_clk) begin
                n_checks++;
                if (beat_sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL %s beat: unexpected strobe at addr %h", name, o_bus_addr);
                end else begin
                    b = beat_sb.pop_front();
                    if (o_bus_addr !== b.addr || o_bus_we !== b.we ||
                        (b.we && o_bus_data !== b.data)) begin
                        n_fail++;
                        $display("FAIL %s beat: got addr=%h we=%b data=%h, want addr=%h we=%b data=%h",
                                 name, o_bus_addr, o_bus_we, o_bus_data, b.addr, b.we, b.data);
                    end
                end
            end
            if (!o_bus_clk && o_bus_we) bad_we = 1;
            if (!stall) begin
                case (sst)
                    0: if (o_bus_clk) sst = 1;
                    1: begin
                        i_bus_data_ready = 1'b1;
                        i_bus_data = rbytes[bi*8 +: 8];
                        sst = 2;
                    end
                    default: if (!o_bus_clk) begin
                        i_bus_data_ready = 1'b0;
                        bi++;
                        sst = 0;
                    end
                endcase
            end
            prev_clk = o_bus_clk;
            if (o_done) begin
                done = 1;
                r = res_sb.pop_front();
                n_checks++;
                if (o_err !== r.err || o_rdata !== r.rdata || cyc != r.lat ||
                    o_bus_clk !== 1'b0 || beat_sb.size() != 0) begin
                    n_fail++;
                    $display("FAIL %s done: got err=%b rdata=%h lat=%0d clk=%b left=%0d, want err=%b rdata=%h lat=%0d clk=0 left=0",
                             name, o_err, o_rdata, cyc, o_bus_clk, beat_sb.size(), r.err, r.rdata, r.lat);
                end
            end else begin
                @(negedge i_clk);
                cyc++;
            end
        end
        i_bus_data_ready = 1'b0;
        if (!done) begin
            n_checks++; n_fail++;
            $display("FAIL %s timeout: no o_done within %0d cycles, want o_done", name, cyc);
            beat_sb.delete();
            res_sb.delete();
        end else begin
            last_rdata = r.rdata;
        end
        @(negedge i_clk);
        n_checks++;
        if (o_done !== 1'b0 || o_busy !== 1'b0 || bad_we) begin
            n_fail++;
            $display("FAIL %s after: got done=%b busy=%b we_without_clk=%b, want 0 0 0",
                     name, o_done, o_busy, bad_we);
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        repeat (2) @(negedge i_clk);
        n_checks++;
        if ({o_bus_clk, o_bus_we, o_busy, o_done, o_err} !== 5'b0 ||
            o_bus_addr !== 32'h0 || o_bus_data !== 8'h0 || o_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset: got clk=%b we=%b busy=%b done=%b err=%b addr=%h data=%h rdata=%h, want all zero",
                     o_bus_clk, o_bus_we, o_busy, o_done, o_err, o_bus_addr, o_bus_data, o_rdata);
        end
        i_rst = 1'b0;
        last_rdata = '0;
        @(negedge i_clk);
    endtask

    task automatic test_read4();
        run_xfer(1'b0, 32'h0000_1000, 2'd2, 1'b0, 32'h0, 32'h1234_5678, 0, 0, "read4");
    endtask

    task automatic test_read_sext();
        run_xfer(1'b0, 32'h0000_0040, 2'd0, 1'b1, 32'h0, 32'h0000_0080, 0, 0, "read_sext1");
        run_xfer(1'b0, 32'h0000_0040, 2'd0, 1'b0, 32'h0, 32'h0000_0080, 0, 0, "read_sext0");
        run_xfer(1'b0, 32'h0000_0050, 2'd1, 1'b1, 32'h0, 32'h0000_9A01, 0, 0, "read2_sext");
    endtask

    task automatic test_write_wrap();
        run_xfer(1'b1, 32'hFFFF_FFFF, 2'd1, 1'b0, 32'h0000_BEEF, 32'h0, 0, 0, "write_wrap");
    endtask

    task automatic test_reserved_size();
        run_xfer(1'b0, 32'h0000_0100, 2'd3, 1'b0, 32'h0, 32'hAAAA_AAAA, 0, 0, "size3");
    endtask

    task automatic test_ignore_busy();
        run_xfer(1'b0, 32'h0000_0200, 2'd1, 1'b0, 32'h0, 32'h0000_C3D4, 0, 1, "busy_req");
    endtask

    task automatic test_reset_abort();
        int sst;
        sst = 0;
        i_we = 1'b0; i_addr = 32'h0000_2000; i_size = 2'd2; i_sext = 1'b0;
        i_req = 1'b1;
        @(negedge i_clk);
        i_req = 1'b0;
        for (int cyc = 1; cyc < 6; cyc++) begin
            case (sst)
                0: if (o_bus_clk) sst = 1;
                1: begin i_bus_data_ready = 1'b1; i_bus_data = 8'h11; sst = 2; end
                default: if (!o_bus_clk) begin i_bus_data_ready = 1'b0; sst = 0; end
            endcase
            @(negedge i_clk);
        end
        n_checks++;
        if (o_bus_clk !== 1'b1 || o_bus_addr !== 32'h0000_2001) begin
            n_fail++;
            $display("FAIL abort_beat2: got clk=%b addr=%h, want clk=1 addr=00002001", o_bus_clk, o_bus_addr);
        end
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        n_checks++;
        if (o_bus_clk !== 1'b0 || o_busy !== 1'b0 || o_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL abort_reset: got clk=%b busy=%b rdata=%h, want 0 0 0", o_bus_clk, o_busy, o_rdata);
        end
        last_rdata = '0;
        begin
            bit saw_done;
            saw_done = 0;
            repeat (8) begin
                if (o_done) saw_done = 1;
                @(negedge i_clk);
            end
            n_checks++;
            if (saw_done) begin
                n_fail++;
                $display("FAIL abort_nodone: got o_done after reset, want none");
            end
        end
        run_xfer(1'b0, 32'h0000_3000, 2'd0, 1'b0, 32'h0, 32'h0000_005A, 0, 0, "after_abort");
    endtask

`ifdef BUS_TIMEOUT_EN
    task automatic test_timeout();
        run_xfer(1'b0, 32'h0000_4000, 2'd0, 1'b0, 32'h0, 32'h0000_0077, 1, 0, "timeout");
    endtask
`endif

    task automatic test_random();
        for (int k = 0; k < 6; k++) begin
            logic        we;
            logic [1:0]  size;
            we   = 1'($urandom_range(0, 1));
            size = 2'($urandom_range(0, 2));
            run_xfer(we, $urandom, size, 1'($urandom_range(0, 1)), $urandom, $urandom,
                     0, 0, "random");
        end
    endtask

    initial begin
        i_rst = 1'b0; i_req = 1'b0; i_we = 1'b0; i_addr = '0; i_size = '0;
        i_sext = 1'b0; i_wdata = '0; i_bus_data = '0; i_bus_data_ready = 1'b0;
        @(negedge i_clk);
        test_reset();
        test_read4();
        test_read_sext();
        test_write_wrap();
        test_reserved_size();
        test_ignore_busy();
        test_reset_abort();
`ifdef BUS_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
